// File: rtl/seq_add_sub_unit.sv
// Slice-serial add/subtract unit: WIDTH-bit operands processed CHUNK bits per clock, LSB first,
// with optional signed saturation, NZCV-style flags and valid/ready on both sides.
//
// state | meaning
// IDLE  | ready for operands, in_ready=1
// CALC  | adding one CHUNK-bit slice per clock
// DONE  | result and flags valid, held until out_ready
module seq_add_sub_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             sign_a_q;
  logic             sub_q;
  logic             sat_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] result_q;
  logic             carry_f_q;
  logic             overflow_q;
  logic             zero_q;
  logic             negative_q;

  logic [CHUNK-1:0] a_s;
  logic [CHUNK-1:0] b_s;
  logic [CHUNK:0]   slice_full;
  logic [CHUNK-1:0] s_s;
  logic             cout_s;
  logic             cmsb_s;
  logic             ovf_final;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] res_final;

  // Operands shift right each slice; finished slices enter the sum register from the top,
  // so after NCHUNK slices slice 0 sits at bit 0.
  always_comb begin
    a_s        = a_q[CHUNK-1:0];
    b_s        = b_q[CHUNK-1:0];
    slice_full = {1'b0, a_s} + {1'b0, b_s} + {{CHUNK{1'b0}}, carry_q};
    s_s        = slice_full[CHUNK-1:0];
    cout_s     = slice_full[CHUNK];
    cmsb_s     = s_s[CHUNK-1] ^ a_s[CHUNK-1] ^ b_s[CHUNK-1];
    ovf_final  = cmsb_s ^ cout_s;
    sum_next   = (sum_q >> CHUNK) | (WIDTH'(s_s) << (WIDTH - CHUNK));
    res_final  = sum_next;
    if (sat_q && ovf_final) begin
      res_final = sign_a_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      sign_a_q   <= 1'b0;
      sub_q      <= 1'b0;
      sat_q      <= 1'b0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      carry_f_q  <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= sub ? ~b : b;
            sign_a_q <= a[WIDTH-1];
            sub_q    <= sub;
            sat_q    <= sat;
            carry_q  <= sub;
            sum_q    <= '0;
            cnt_q    <= CNT_LOAD;
            state_q  <= CALC;
          end
        end
        CALC: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          sum_q   <= sum_next;
          carry_q <= cout_s;
          if (cnt_q == '0) begin
            result_q   <= res_final;
            carry_f_q  <= sub_q ? ~cout_s : cout_s;
            overflow_q <= ovf_final;
            zero_q     <= (res_final == '0);
            negative_q <= res_final[WIDTH-1];
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry     = carry_f_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;

endmodule

// File: tb/tb_seq_add_sub_unit.sv
// Directed bench for seq_add_sub_unit (WIDTH=16, CHUNK=4): hand-computed vectors, latency,
// backpressure hold, issue interval and mid-operation reset.
module tb_seq_add_sub_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        sat;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic        negative;

  int n_checks = 0;
  int n_fails  = 0;

  seq_add_sub_unit #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one operation at a negedge, measures latency to out_valid and checks result/flags.
  // Leaves the bench at the negedge where out_valid was first seen.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic sv, input logic satv, input logic [15:0] exp_r,
                        input logic ec, input logic ev, input logic ez, input logic en);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; a = av; b = bv; sub = sv; sat = satv;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = ~sv; sat = ~satv;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, " latency"}, lat, 32'd4);
    chk({tag, " result"},   {16'b0, result}, {16'b0, exp_r});
    chk({tag, " carry"},    {31'b0, carry},    {31'b0, ec});
    chk({tag, " overflow"}, {31'b0, overflow}, {31'b0, ev});
    chk({tag, " zero"},     {31'b0, zero},     {31'b0, ez});
    chk({tag, " negative"}, {31'b0, negative}, {31'b0, en});
  endtask

  initial begin
    int acc[$];
    int seen;
    logic [15:0] held;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset in_ready",  {31'b0, in_ready},  32'd1);
    chk("reset result",    {16'b0, result},    32'd0);
    chk("reset flags", {28'b0, carry, overflow, zero, negative}, 32'd0);
    rst_n = 1'b1;

    //       tag        A        B        sub   sat   result   C     V     Z     N
    run_op("add1",   16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub1",   16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("sub0",   16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("addov",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("addsat", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("addwrap",16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("subov",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("subsat", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("negsat", 16'h8000, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);

    // Backpressure: hold in DONE while inputs wiggle
    @(negedge clk);
    out_ready = 1'b0;
    run_op("hold", 16'h0100, 16'h0023, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b0, 1'b0);
    held = result;
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid; a = 16'h1111 * 16'(i); b = ~a; sub = ~sub; sat = ~sat;
      @(posedge clk);
      @(negedge clk);
      chk("hold out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold in_ready",  {31'b0, in_ready},  32'd0);
      chk("hold result",    {16'b0, result},    {16'b0, held});
      chk("hold flags", {28'b0, carry, overflow, zero, negative}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release in_ready",  {31'b0, in_ready},  32'd1);
    chk("release out_valid", {31'b0, out_valid}, 32'd0);

    // Back-to-back issue: in_valid held high, record the cycles in which an accept happens
    in_valid = 1'b1; a = 16'h0101; b = 16'h0202; sub = 1'b0; sat = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) acc.push_back(i);
      if (out_valid) chk("b2b result", {16'b0, result}, 32'h0303);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b accepts", acc.size(), 32'd4);
    if (acc.size() >= 3) begin
      chk("b2b interval1", acc[1] - acc[0], 32'd6);
      chk("b2b interval2", acc[2] - acc[1], 32'd6);
    end
    repeat (8) @(negedge clk);

    // Reset in the middle of CALC, after slice 1
    chk("pre-rst result nonzero", {31'b0, (result != 16'h0)}, 32'd1);
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst result",    {16'b0, result},    32'd0);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst flags", {28'b0, carry, overflow, zero, negative}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst in_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("post-rst no out_valid", seen, 32'd0);
    run_op("after rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
